// File: rtl/definitions_pkg.sv
// Shared definitions for the configurable UART receiver: FSM state encoding,
// default oversample ratio and the 2-of-3 vote helper.
package definitions_pkg;

  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    RECOVER = 3'd5
  } uart_rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Signal bundle between a serial-line/config source and the UART receiver,
// with the receiver's result outputs flowing back.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 s_tick;
  logic                 parity_en;
  logic                 parity_odd;
  logic [DATA_BITS-1:0] dout;
  logic                 rx_done;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;

  modport master (
    output rx, s_tick, parity_en, parity_odd,
    input  dout, rx_done, parity_err, frame_err, break_det
  );

  modport slave (
    input  rx, s_tick, parity_en, parity_odd,
    output dout, rx_done, parity_err, frame_err, break_det
  );
endinterface

// File: rtl/uart_rx_vote.sv
// 3-sample majority register used when UART_RX_MAJORITY_EN is defined:
// holds the two earlier samples of a bit and votes them against the current one.
module uart_rx_vote
  import definitions_pkg::*;
(
  input  logic clk,
  input  logic rstN,
  input  logic en,
  input  logic din,
  output logic maj
);

  logic [1:0] hist_q;

  // Reset to the idle-line level so a vote never sees spurious zeros.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      hist_q <= 2'b11;
    end else if (en) begin
      hist_q <= {hist_q[0], din};
    end
  end

  assign maj = maj3(hist_q[1], hist_q[0], din);

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with optional parity, 1/2 stop bits, frame-error
// recovery and break detection. Define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_rx_cfg
  import definitions_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 rx,
  input  logic                 s_tick,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_MID       = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST      = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_DATA_LAST = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] N_STOP_LAST = NW'(STOP_BITS - 1);

  logic [1:0] sync_q;
  logic       rx_s;
  logic       bit_sample;

  uart_rx_state_t       state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 pen_q, pen_d, podd_q, podd_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, zero_q, zero_d;
  logic [DATA_BITS-1:0] dout_d;
  logic                 done_d, perr_out_d, ferr_out_d, brk_d;

  // NOTE: synchroniser flops reset to 1 (idle line) so leaving reset never
  // looks like a start bit.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic vote_en;
  assign vote_en = s_tick && (s_q == SW'(OVERSAMPLE - 3) || s_q == SW'(OVERSAMPLE - 2));

  uart_rx_vote u_vote (
    .clk  (clk),
    .rstN (rstN),
    .en   (vote_en),
    .din  (rx_s),
    .maj  (bit_sample)
  );
`else
  assign bit_sample = rx_s;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      s_q        <= '0;
      n_q        <= '0;
      shreg_q    <= '0;
      pen_q      <= 1'b0;
      podd_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b0;
      dout       <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      n_q        <= n_d;
      shreg_q    <= shreg_d;
      pen_q      <= pen_d;
      podd_q     <= podd_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      zero_q     <= zero_d;
      dout       <= dout_d;
      rx_done    <= done_d;
      parity_err <= perr_out_d;
      frame_err  <= ferr_out_d;
      break_det  <= brk_d;
    end
  end

  // NOTE: every output of this block gets a default first; a missing default
  // on any path would infer a latch.
  always_comb begin
    logic frame_bad;
    logic all_zero;

    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    shreg_d    = shreg_q;
    pen_d      = pen_q;
    podd_d     = podd_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    zero_d     = zero_q;
    dout_d     = dout;
    done_d     = 1'b0;
    perr_out_d = 1'b0;
    ferr_out_d = 1'b0;
    brk_d      = 1'b0;
    frame_bad  = ferr_q | ~bit_sample;
    all_zero   = zero_q & ~bit_sample;

    if (s_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            s_d     = '0;
          end
        end

        START: begin
          if (s_q == S_MID) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
              pen_d   = parity_en;
              podd_d  = parity_odd;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
              zero_d  = 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end

        DATA: begin
          if (s_q == S_LAST) begin
            shreg_d = {bit_sample, shreg_q[DATA_BITS-1:1]};
            zero_d  = all_zero;
            s_d     = '0;
            if (n_q == N_DATA_LAST) begin
              n_d     = '0;
              state_d = pen_q ? PARITY : STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end

        PARITY: begin
          if (s_q == S_LAST) begin
            perr_d  = (^shreg_q) ^ bit_sample ^ podd_q;
            zero_d  = all_zero;
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end

        STOP: begin
          if (s_q == S_LAST) begin
            s_d = '0;
            if (n_q == N_STOP_LAST) begin
              n_d        = '0;
              done_d     = 1'b1;
              dout_d     = shreg_q;
              perr_out_d = perr_q & pen_q;
              ferr_out_d = frame_bad;
              brk_d      = all_zero;
              state_d    = frame_bad ? RECOVER : IDLE;
            end else begin
              n_d    = n_q + 1'b1;
              ferr_d = frame_bad;
              zero_d = all_zero;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end

        RECOVER: begin
          // Wait for the line to return high before hunting for a new start bit.
          if (rx_s) state_d = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg (OVERSAMPLE=16, DATA_BITS=8, STOP_BITS=1):
// frames are expected from word-level rules; a monitor checks every rx_done.
module tb_uart_rx_cfg;
  import definitions_pkg::*;

`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif
  localparam int OS = 16;

  typedef struct {
    logic [7:0] dout;
    bit         perr;
    bit         ferr;
    bit         brk;
  } exp_t;

  logic clk;
  logic rstN;
  int   vectors;
  int   errors;
  exp_t exp_q[$];
  bit   line_q[$];

  uart_rx_cfg_if #(.DATA_BITS(8)) bus ();

  uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .rx         (bus.rx),
    .s_tick     (bus.s_tick),
    .parity_en  (bus.parity_en),
    .parity_odd (bus.parity_odd),
    .dout       (bus.dout),
    .rx_done    (bus.rx_done),
    .parity_err (bus.parity_err),
    .frame_err  (bus.frame_err),
    .break_det  (bus.break_det)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One oversample period: line value settles through the synchroniser, then s_tick pulses.
  task automatic tick(input bit v);
    bus.rx     = v;
    bus.s_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.s_tick = 1'b1;
    @(negedge clk);
    bus.s_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1);
  endtask

  task automatic build_frame(input logic [7:0] d, input bit pen, input bit pbit,
                             input bit stop, input int glitch);
    line_q.delete();
    repeat (OS) line_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int t = 0; t < OS; t++)
        line_q.push_back((glitch == i && t == OS / 2) ? 1'b0 : d[i]);
    if (pen) repeat (OS) line_q.push_back(pbit);
    repeat (OS) line_q.push_back(stop);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pen, input bit podd,
                            input bit pbit, input bit stop, input int glitch);
    exp_t       e;
    logic [7:0] seen;
    seen = d;
    if (glitch >= 0 && !MAJ) seen[glitch] = 1'b0;
    e.dout = seen;
    e.perr = pen && (pbit != (($countones(seen) % 2 == 1) ^ podd));
    e.ferr = !stop;
    e.brk  = (seen == 8'h00) && !stop && (!pen || !pbit);
    exp_q.push_back(e);
    bus.parity_en  = pen;
    bus.parity_odd = podd;
    build_frame(d, pen, pbit, stop, glitch);
    for (int i = 0; i < line_q.size(); i++) begin
      // Configuration pins only matter at the start bit; scramble them afterwards.
      if (i == OS) begin
        bus.parity_en  = 1'($urandom);
        bus.parity_odd = 1'($urandom);
      end
      tick(line_q[i]);
    end
    idle(20);
  endtask

  // Monitor: every rx_done pops one expected frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstN) begin
        if (bus.rx_done) begin
          if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_rx_done: got dout=0x%0h, expected no frame", bus.dout);
          end else begin
            e = exp_q.pop_front();
            check("dout",       32'(bus.dout),       32'(e.dout));
            check("parity_err", 32'(bus.parity_err), 32'(e.perr));
            check("frame_err",  32'(bus.frame_err),  32'(e.ferr));
            check("break_det",  32'(bus.break_det),  32'(e.brk));
          end
        end else if (bus.parity_err || bus.frame_err || bus.break_det) begin
          vectors++;
          errors++;
          $display("FAIL flags_without_done: got p=%0b f=%0b b=%0b, expected 0",
                   bus.parity_err, bus.frame_err, bus.break_det);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    bit         pen, podd, pbit, stop;

    vectors        = 0;
    errors         = 0;
    rstN           = 1'b0;
    bus.rx         = 1'b1;
    bus.s_tick     = 1'b0;
    bus.parity_en  = 1'b0;
    bus.parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dout",    32'(bus.dout),       32'h0);
    check("reset_rx_done", 32'(bus.rx_done),    32'h0);
    check("reset_flags",   32'({bus.parity_err, bus.frame_err, bus.break_det}), 32'h0);
    rstN = 1'b1;
    idle(20);

    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, -1);

    // Short low pulse: start check fails, no frame.
    repeat (4) tick(1'b0);
    repeat (8) tick(1'b1);
    check("glitch_state_idle", 32'(dut.state_q), 32'(IDLE));
    idle(10);

    // Break: line held low for 20 bit times, then a normal frame.
    exp_q.push_back('{dout: 8'h00, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
    bus.parity_en = 1'b0;
    repeat (20 * OS) tick(1'b0);
    idle(20);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1);

    // Reset in the middle of bit 4.
    build_frame(8'h96, 1'b0, 1'b0, 1'b1, -1);
    for (int i = 0; i < OS + 4 * OS + OS / 2; i++) tick(line_q[i]);
    rstN   = 1'b0;
    bus.rx = 1'b1;
    #1;
    check("midreset_dout",    32'(bus.dout),    32'h0);
    check("midreset_rx_done", 32'(bus.rx_done), 32'h0);
    check("midreset_flags",   32'({bus.parity_err, bus.frame_err, bus.break_det}), 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    idle(20);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1);

    // Single-tick glitch at the bit-2 sample point.
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 2);

    for (int k = 0; k < 14; k++) begin
      d    = 8'($urandom);
      if ($urandom_range(3) == 0) d = 8'h00;
      pen  = 1'($urandom);
      podd = 1'($urandom);
      pbit = 1'($urandom);
      stop = ($urandom_range(3) != 0);
      send_frame(d, pen, podd, pbit, stop, -1);
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      errors++;
      $display("FAIL missing_rx_done: got no frame, expected dout=0x%0h", e.dout);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
